// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data cache access sequencer (IDLE/BUSY/DONE).
// Ports: clk/rst; mem_* request from MEM stage; d_mem_* cache bus;
//   mem_stall freezes IF..MEM; wb_d_mem_data registered, offset-shifted
//   load word; mem_misaligned pulses for misaligned or illegal requests.
module dmem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_alu_out,
   input  logic [31:0] mem_rs2_out,
   output logic [31:0] d_mem_address,
   output logic        d_mem_read,
   output logic        d_mem_write,
   output logic [3:0]  d_mem_byte_enable,
   output logic [31:0] d_mem_wdata,
   input  logic [31:0] d_mem_rdata,
   input  logic        d_mem_resp,
   output logic        mem_stall,
   output logic [31:0] wb_d_mem_data,
   output logic        mem_misaligned
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] wb_q, wb_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  off_q, off_d;
   logic        wr_q, wr_d;

   logic [1:0]  off;
   logic [1:0]  sz;
   logic        one_dir;
   logic        both;
   logic        mis;
   logic        illegal;
   logic        idle;
   logic        accept;
   logic        reject;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;

   assign off = mem_alu_out[1:0];
   assign sz  = mem_funct3[1:0];

   // Request classification; unsupported funct3 codes count as illegal.
   always_comb begin
      one_dir = mem_read ^ mem_write;
      both    = mem_read & mem_write;
      mis     = ((sz == 2'b10) && (off != 2'b00)) ||
                ((sz == 2'b01) && off[0]);
      illegal = (sz == 2'b11) ||
                (mem_funct3[2] && (mem_write || sz[1]));
      // Gate with rst so outputs read zero while reset is held.
      idle    = (state_q == IDLE) && !rst;
      accept  = idle && mem_valid && one_dir && !mis && !illegal;
      reject  = idle && mem_valid &&
                (both || (one_dir && (mis || illegal)));
   end

   // Store lane positioning; loads always read the full word.
   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = mem_rs2_out;
      if (mem_write) begin
         unique case (1'b1)
            (sz == 2'b00): begin
               lane_be    = 4'b0001 << off;
               lane_wdata = {4{mem_rs2_out[7:0]}};
            end
            (sz == 2'b01): begin
               lane_be    = 4'b0011 << off;
               lane_wdata = {2{mem_rs2_out[15:0]}};
            end
            default: begin
               lane_be    = 4'b1111;
               lane_wdata = mem_rs2_out;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wb_d    = wb_q;
      be_d    = be_q;
      off_d   = off_q;
      wr_d    = wr_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = {mem_alu_out[31:2], 2'b00};
               wdata_d = lane_wdata;
               be_d    = lane_be;
               off_d   = off;
               wr_d    = mem_write;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (d_mem_resp) begin
               state_d = DONE;
               if (!wr_q) wb_d = d_mem_rdata >> {off_q, 3'b000};
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wb_q    <= '0;
         be_q    <= '0;
         off_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wb_q    <= wb_d;
         be_q    <= be_d;
         off_q   <= off_d;
         wr_q    <= wr_d;
      end
   end

   assign d_mem_address     = addr_q;
   assign d_mem_byte_enable = be_q;
   assign d_mem_wdata       = wdata_q;
   assign d_mem_read        = (state_q == BUSY) && !wr_q;
   assign d_mem_write       = (state_q == BUSY) && wr_q;
   assign mem_stall         = accept || (state_q == BUSY);
   assign mem_misaligned    = reject;
   assign wb_d_mem_data     = wb_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed checks of dmem_access_unit.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_dmem_access_unit;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_out;
   logic [31:0] mem_rs2_out;
   logic [31:0] d_mem_address;
   logic        d_mem_read;
   logic        d_mem_write;
   logic [3:0]  d_mem_byte_enable;
   logic [31:0] d_mem_wdata;
   logic [31:0] d_mem_rdata;
   logic        d_mem_resp;
   logic        mem_stall;
   logic [31:0] wb_d_mem_data;
   logic        mem_misaligned;

   int n_chk, n_pass;
   int n_rd, n_wr, n_st, n_mis, n_both, n_rd_iss, n_wr_iss;
   logic prev_rd, prev_wr;

   dmem_access_unit dut (
      .clk               (clk),
      .rst               (rst),
      .mem_valid         (mem_valid),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_funct3        (mem_funct3),
      .mem_alu_out       (mem_alu_out),
      .mem_rs2_out       (mem_rs2_out),
      .d_mem_address     (d_mem_address),
      .d_mem_read        (d_mem_read),
      .d_mem_write       (d_mem_write),
      .d_mem_byte_enable (d_mem_byte_enable),
      .d_mem_wdata       (d_mem_wdata),
      .d_mem_rdata       (d_mem_rdata),
      .d_mem_resp        (d_mem_resp),
      .mem_stall         (mem_stall),
      .wb_d_mem_data     (wb_d_mem_data),
      .mem_misaligned    (mem_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drv(input logic v, input logic r, input logic w,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
      mem_valid   = v;
      mem_read    = r;
      mem_write   = w;
      mem_funct3  = f3;
      mem_alu_out = a;
      mem_rs2_out = d;
   endtask

   task automatic clr();
      n_rd = 0; n_wr = 0; n_st = 0; n_mis = 0; n_both = 0;
      n_rd_iss = 0; n_wr_iss = 0;
   endtask

   task automatic samp();
      @(negedge clk);
      if (d_mem_read) n_rd++;
      if (d_mem_write) n_wr++;
      if (mem_stall) n_st++;
      if (mem_misaligned) n_mis++;
      if (d_mem_read && d_mem_write) n_both++;
      if (d_mem_read && !prev_rd) n_rd_iss++;
      if (d_mem_write && !prev_wr) n_wr_iss++;
      prev_rd = d_mem_read;
      prev_wr = d_mem_write;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      prev_rd = 1'b0; prev_wr = 1'b0;
      clr();
      rst = 1'b1;
      d_mem_resp = 1'b0;
      d_mem_rdata = '0;
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);

      // reset state
      samp();
      chk("rst_wb", wb_d_mem_data, 32'h0);
      chk("rst_stall", 32'(mem_stall), 32'h0);
      chk("rst_mis", 32'(mem_misaligned), 32'h0);
      chk("rst_be", 32'(d_mem_byte_enable), 32'h0);
      chk("rst_rdwr", 32'({d_mem_read, d_mem_write}), 32'h0);
      chk("rst_addr", d_mem_address, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: lw 0x1004, resp on second BUSY cycle
      clr();
      drv(1, 1, 0, 3'b010, 32'h0000_1004, 32'h0);
      samp();
      chk("s1_acc_stall", 32'(mem_stall), 32'h1);
      chk("s1_acc_rd", 32'(d_mem_read), 32'h0);
      adv();
      samp();
      chk("s1_addr", d_mem_address, 32'h0000_1004);
      adv();
      d_mem_resp = 1'b1; d_mem_rdata = 32'hDEAD_BEEF;
      samp();
      adv();
      d_mem_resp = 1'b0;
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);
      samp();
      chk("s1_wb", wb_d_mem_data, 32'hDEAD_BEEF);
      chk("s1_done_stall", 32'(mem_stall), 32'h0);
      chk("s1_rd_cycles", 32'(n_rd), 32'd2);
      chk("s1_stall_cycles", 32'(n_st), 32'd3);
      adv();

      // 2: lbu 0x2003
      clr();
      drv(1, 1, 0, 3'b100, 32'h0000_2003, 32'h0);
      samp();
      adv();
      d_mem_resp = 1'b1; d_mem_rdata = 32'h8877_6655;
      samp();
      chk("s2_addr", d_mem_address, 32'h0000_2000);
      chk("s2_be", 32'(d_mem_byte_enable), 32'hF);
      chk("s2_rd", 32'(d_mem_read), 32'h1);
      adv();
      d_mem_resp = 1'b0;
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);
      samp();
      chk("s2_wb", wb_d_mem_data, 32'h0000_0088);
      adv();

      // 3: sh 0x3002
      clr();
      drv(1, 0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD);
      samp();
      adv();
      d_mem_resp = 1'b1; d_mem_rdata = 32'hFFFF_FFFF;
      samp();
      chk("s3_be", 32'(d_mem_byte_enable), 32'hC);
      chk("s3_wdata", d_mem_wdata, 32'hABCD_ABCD);
      chk("s3_addr", d_mem_address, 32'h0000_3000);
      chk("s3_rdwr", 32'({d_mem_read, d_mem_write}), 32'h1);
      adv();
      d_mem_resp = 1'b0;
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);
      samp();
      chk("s3_wb_kept", wb_d_mem_data, 32'h0000_0088);
      adv();

      // 4: misaligned lw/lh, both-direction request, stray resp
      clr();
      drv(1, 1, 0, 3'b010, 32'h0000_4002, 32'h0);
      samp();
      chk("s4_lw_mis", 32'(mem_misaligned), 32'h1);
      chk("s4_lw_stall", 32'(mem_stall), 32'h0);
      adv();
      drv(1, 1, 0, 3'b001, 32'h0000_4001, 32'h0);
      samp();
      chk("s4_lh_mis", 32'(mem_misaligned), 32'h1);
      chk("s4_lh_stall", 32'(mem_stall), 32'h0);
      adv();
      drv(1, 1, 1, 3'b010, 32'h0000_4000, 32'h0);
      samp();
      chk("s4_both_mis", 32'(mem_misaligned), 32'h1);
      adv();
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);
      d_mem_resp = 1'b1; d_mem_rdata = 32'h1234_5678;
      samp();
      chk("s4_idle_mis", 32'(mem_misaligned), 32'h0);
      adv();
      d_mem_resp = 1'b0;
      samp();
      chk("s4_no_rd", 32'(n_rd + n_wr), 32'd0);
      chk("s4_no_stall", 32'(n_st), 32'd0);
      chk("s4_mis_count", 32'(n_mis), 32'd3);
      chk("s4_idle_resp", wb_d_mem_data, 32'h0000_0088);
      adv();

      // 5: reset mid-BUSY for sb, late resp after release
      clr();
      drv(1, 0, 1, 3'b000, 32'h0000_5001, 32'h5A5A_5AA5);
      samp();
      adv();
      samp();
      chk("s5_wr", 32'(d_mem_write), 32'h1);
      chk("s5_be", 32'(d_mem_byte_enable), 32'h2);
      chk("s5_wdata", d_mem_wdata, 32'hA5A5_A5A5);
      #2;
      rst = 1'b1;
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);
      #1;
      chk("s5_rst_wr", 32'(d_mem_write), 32'h0);
      chk("s5_rst_stall", 32'(mem_stall), 32'h0);
      chk("s5_rst_be", 32'(d_mem_byte_enable), 32'h0);
      chk("s5_rst_wb", wb_d_mem_data, 32'h0);
      adv();
      rst = 1'b0;
      adv();
      d_mem_resp = 1'b1; d_mem_rdata = 32'hFFFF_FFFF;
      samp();
      chk("s5_late_rdwr", 32'({d_mem_read, d_mem_write}), 32'h0);
      chk("s5_late_stall", 32'(mem_stall), 32'h0);
      adv();
      d_mem_resp = 1'b0;
      samp();
      chk("s5_late_wb", wb_d_mem_data, 32'h0);
      chk("s5_after_stall", 32'(mem_stall), 32'h0);
      adv();

      // 6: sw then lw, inputs held through stall and DONE
      clr();
      prev_rd = 1'b0; prev_wr = 1'b0;
      drv(1, 0, 1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D);
      samp();
      adv();
      samp();
      chk("s6_sw_be", 32'(d_mem_byte_enable), 32'hF);
      chk("s6_sw_wdata", d_mem_wdata, 32'hCAFE_F00D);
      chk("s6_sw_addr", d_mem_address, 32'h0000_6000);
      adv();
      d_mem_resp = 1'b1;
      samp();
      adv();
      d_mem_resp = 1'b0;
      samp();
      chk("s6_gap_rdwr", 32'({d_mem_read, d_mem_write}), 32'h0);
      chk("s6_gap_stall", 32'(mem_stall), 32'h0);
      adv();
      drv(1, 1, 0, 3'b010, 32'h0000_6004, 32'h0);
      samp();
      chk("s6_lw_stall", 32'(mem_stall), 32'h1);
      adv();
      d_mem_resp = 1'b1; d_mem_rdata = 32'h1122_3344;
      samp();
      chk("s6_lw_addr", d_mem_address, 32'h0000_6004);
      adv();
      d_mem_resp = 1'b0;
      drv(0, 0, 0, 3'b000, 32'h0, 32'h0);
      samp();
      chk("s6_wb", wb_d_mem_data, 32'h1122_3344);
      adv();
      samp();
      chk("s6_wr_issues", 32'(n_wr_iss), 32'd1);
      chk("s6_rd_issues", 32'(n_rd_iss), 32'd1);
      chk("s6_wr_cycles", 32'(n_wr), 32'd2);
      chk("s6_rd_cycles", 32'(n_rd), 32'd1);
      chk("s6_both", 32'(n_both), 32'd0);
      adv();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 The block SHALL have these ports:
- clk  in  1  pipeline clock
- rst  in  1  async active-high reset
- mem_valid  in  1  MEM stage holds a live instruction
- mem_read  in  1  load in MEM
- mem_write  in  1  store in MEM
- mem_funct3  in  3  RV32I load/store funct3
- mem_alu_out  in  32  effective byte address
- mem_rs2_out  in  32  store data, unaligned
- d_mem_address  out  32  word-aligned cache address
- d_mem_read  out  1  cache read request
- d_mem_write  out  1  cache write request
- d_mem_byte_enable  out  4  write lane mask
- d_mem_wdata  out  32  lane-positioned store data
- d_mem_rdata  in  32  cache read data
- d_mem_resp  in  1  cache completion, one-cycle pulse
- mem_stall  out  1  freeze IF..MEM registers
- wb_d_mem_data  out  32  registered load word, right-shifted by byte offset, feeds REGFILEMUX
- mem_misaligned  out  1  misaligned or illegal access flag, one-cycle pulse

Function
REQ-003 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-004 In IDLE, a request SHALL be a cycle with mem_valid=1 and exactly one of mem_read or mem_write set.
REQ-005 A request is misaligned if either holds:
- funct3 is w and addr[1:0]!=0;
- funct3 is h, hu or sh and addr[0]!=0.
REQ-006 For a misaligned request, the block SHALL pulse mem_misaligned=1, issue no cache access, hold mem_stall=0 and stay in IDLE.
REQ-007 If mem_valid=1 with both mem_read and mem_write set, the block SHALL apply the same behaviour as REQ-006.
REQ-008 For an aligned request in IDLE, the block SHALL:
- latch the address, lane mask, write data, offset and direction;
- assert mem_stall=1 combinationally in the same cycle;
- transition to BUSY.
REQ-009 In BUSY, the block SHALL drive d_mem_read or d_mem_write from the latched values only and hold mem_stall=1.
REQ-010 In BUSY, cache inputs SHALL NOT be affected by changes on the mem_* inputs.
REQ-011 On d_mem_resp=1 in BUSY, the block SHALL deassert the request in the next cycle and transition to DONE.
REQ-012 On d_mem_resp=1 in BUSY for a read, the block SHALL register wb_d_mem_data = d_mem_rdata >> (8*offset).
REQ-013 A write SHALL leave wb_d_mem_data unchanged.
REQ-014 In DONE, the block SHALL hold mem_stall=0 for exactly one cycle, issue no request, ignore mem_* inputs, and then return to IDLE.
REQ-015 d_mem_resp SHALL be ignored in IDLE and DONE.
REQ-016 d_mem_address SHALL equal {addr[31:2],2'b00}.
REQ-017 d_mem_byte_enable SHALL be:
- sb: 4'b0001<<offset
- sh: 4'b0011<<offset
- sw: 4'b1111
- all loads: 4'b1111
REQ-018 d_mem_wdata SHALL be:
- sb: {4{rs2[7:0]}}
- sh: {2{rs2[15:0]}}
- sw: rs2
REQ-019 Sign or zero extension SHALL NOT be done in this block; it belongs to REGFILEMUX.
REQ-020 Minimum latency SHALL be 3 cycles per access (IDLE accept, BUSY with resp, DONE).
REQ-021 The stall duration SHALL be 1 plus the number of BUSY cycles.
REQ-022 d_mem_read and d_mem_write SHALL never be asserted simultaneously.
REQ-023 d_mem_read and d_mem_write SHALL be zero outside BUSY.

Reset
REQ-024 On rst=1, asynchronously and at any state, the block SHALL:
- enter IDLE;
- drop any outstanding request;
- clear all outputs and latched fields to 0 (wb_d_mem_data=0, mem_stall=0, mem_misaligned=0, d_mem_byte_enable=0).
REQ-025 A d_mem_resp arriving after reset SHALL be ignored.

Verification
REQ-026 The bench SHALL cover scenario 1:
- stimulus: lw at 0x0000_1004, rdata=0xDEAD_BEEF, resp after 2 BUSY cycles;
- response: address 0x0000_1004, read=1 for 2 cycles, stall=1 for 3 cycles, wb_d_mem_data=0xDEAD_BEEF in DONE.
REQ-027 The bench SHALL cover scenario 2:
- stimulus: lbu at 0x0000_2003, rdata=0x8877_6655;
- response: address 0x0000_2000, wb_d_mem_data=0x0000_0088.
REQ-028 The bench SHALL cover scenario 3:
- stimulus: sh at 0x0000_3002, rs2=0x1234_ABCD;
- response: byte_enable=4'b1100, wdata=0xABCD_ABCD, address 0x0000_3000, wb_d_mem_data unchanged.
REQ-029 The bench SHALL cover scenario 4:
- stimulus: lw at 0x0000_4002, then lh at 0x0000_4001;
- response: mem_misaligned pulses each cycle, no d_mem_read, mem_stall=0 throughout.
REQ-030 The bench SHALL cover scenario 5:
- stimulus: rst asserted mid-BUSY for sb, then d_mem_resp pulse one cycle after reset release;
- response: immediate IDLE, request and stall low, late resp ignored, wb_d_mem_data=0.
REQ-031 The bench SHALL cover scenario 6:
- stimulus: back-to-back sw then lw, with mem_* inputs held through stall;
- response: exactly one access each, DONE gap between them, no duplicate issue.
